qspi_flash_read_engine: RTL

- Downstream stage of the storage controller: serves its word-indexed read requests from external QSPI NOR flash.
- Front side is a simple APB-style select/ready port. Back side drives raw QSPI pins; the storage controller muxes those pins against the programming SPI.
- Issues a Quad Output Fast Read (cmd 0x6B) per request and returns one little-endian 32-bit word.
- Read-only block: write requests are rejected with an error.

---
 rtl/qspi_flash_read_engine_if.sv | 20 ++
 rtl/qspi_flash_read_engine.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_read_engine_if.sv
// Request port of the QSPI flash read engine.
// Requester holds psel until a one-cycle ready pulse comes back.
interface qspi_flash_read_engine_if;
  logic [31:0] s_paddr;
  logic        s_psel;
  logic        s_pwrite;
  logic        s_pready;
  logic [31:0] s_prdata;
  logic        s_pslverr;

  modport master (
    output s_paddr, s_psel, s_pwrite,
    input  s_pready, s_prdata, s_pslverr
  );

  modport slave (
    input  s_paddr, s_psel, s_pwrite,
    output s_pready, s_prdata, s_pslverr
  );
endinterface

// File: rtl/qspi_flash_read_engine.sv
// Quad Output Fast Read engine: one 32-bit little-endian word per request.
// Command and address go out on IO0; data returns as nibbles on IO[3:0].
module qspi_flash_read_engine #(
  parameter int         CLK_DIV    = 2,
  parameter logic [7:0] READ_CMD   = 8'h6B,
  parameter int         DUMMY_CLKS = 8,
  parameter int         CS_HOLD    = 2
) (
  input  logic       clk,
  input  logic       rst,
  qspi_flash_read_engine_if.slave bus,
  input  logic [3:0] qspi_io_i,
  output logic [3:0] qspi_io_o,
  output logic [3:0] qspi_io_t,
  output logic       qspi_ck_o,
  output logic       qspi_cs_o
);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CMD, ADDR,
    DUMMY, DATA, FINISH, CS_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] DUM_LAST = 8'(DUMMY_CLKS - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_HOLD - 2);

  state_t      state_q, state_d, sck_nxt;
  logic [7:0]  div_q, div_d;
  logic [7:0]  bit_q, bit_d, bit_last;
  logic [7:0]  gap_q, gap_d;
  logic        ph_q, ph_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        armed_q;
  logic        acc, wr_acc, rd_acc;
  logic        sck_st, div_end, rise, fall, drv;
  logic        unused_hi;

  assign unused_hi = ^bus.s_paddr[31:22];

  assign acc    = (state_q == IDLE) &&
                  bus.s_psel && armed_q;
  assign wr_acc = acc && bus.s_pwrite;
  assign rd_acc = acc && !bus.s_pwrite;

  assign sck_st  = state_q inside
                   {CMD, ADDR, DUMMY, DATA};
  assign div_end = (div_q == DIV_LAST);
  assign rise    = sck_st && div_end && !ph_q;
  assign fall    = sck_st && div_end && ph_q;

  always_comb begin
    bit_last = 8'd7;
    sck_nxt  = FINISH;
    unique case (state_q)
      CMD: begin
        bit_last = 8'd7;
        sck_nxt  = ADDR;
      end
      ADDR: begin
        bit_last = 8'd23;
        sck_nxt  = (DUMMY_CLKS == 0) ? DATA : DUMMY;
      end
      DUMMY: begin
        bit_last = DUM_LAST;
        sck_nxt  = DATA;
      end
      default: begin
        bit_last = 8'd7;
        sck_nxt  = FINISH;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    unique case (state_q)
      IDLE: begin
        if (rd_acc) begin
          state_d = CS_SETUP;
          div_d   = '0;
          tx_d    = {READ_CMD,
                     bus.s_paddr[21:0], 2'b00};
        end
      end
      CS_SETUP: begin
        if (div_end) begin
          state_d = CMD;
          div_d   = '0;
          ph_d    = 1'b0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      CMD, ADDR, DUMMY, DATA: begin
        div_d = div_end ? '0 : div_q + 8'd1;
        if (div_end) ph_d = ~ph_q;
        if (rise && state_q == DATA)
          rx_d = {rx_q[27:0], qspi_io_i};
        // drive values only move at the end of a high phase
        if (fall) begin
          tx_d  = {tx_q[30:0], 1'b0};
          bit_d = bit_q + 8'd1;
        end
        if (fall && bit_q == bit_last) begin
          bit_d   = '0;
          state_d = sck_nxt;
        end
      end
      FINISH: begin
        gap_d   = '0;
        state_d = (CS_HOLD > 1) ? CS_GAP : IDLE;
      end
      CS_GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else gap_d = gap_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      div_q         <= '0;
      ph_q          <= 1'b0;
      bit_q         <= '0;
      gap_q         <= '0;
      tx_q          <= '0;
      rx_q          <= '0;
      armed_q       <= 1'b1;
      bus.s_pready  <= 1'b0;
      bus.s_pslverr <= 1'b0;
      bus.s_prdata  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      if (acc) armed_q <= 1'b0;
      else if (!bus.s_psel) armed_q <= 1'b1;
      bus.s_pready  <= wr_acc ||
                       (state_d == FINISH);
      bus.s_pslverr <= wr_acc;
      // first nibble received is the high half of byte 0
      if (state_d == FINISH)
        bus.s_prdata <= {rx_q[7:0], rx_q[15:8],
                         rx_q[23:16], rx_q[31:24]};
    end
  end

  assign drv = state_q inside
               {CS_SETUP, CMD, ADDR};

  assign qspi_cs_o = !(state_q inside
                     {CS_SETUP, CMD, ADDR, DUMMY, DATA});
  assign qspi_ck_o = sck_st && ph_q;
  assign qspi_io_t = drv ? 4'b0010 : 4'hF;
  assign qspi_io_o = drv ? {3'b110, tx_q[31]}
                         : 4'h0;

endmodule
